imem_loader: RTL and testbench

Program loader that writes the instruction memory from a byte stream. It sits between a host/debug byte source and the IF-stage instruction memory write port. It assembles big-endian bytes into 32-bit instructions, writes them at consecutive word addresses starting at 0, and stops on the halt word 32'hFC000000 or when memory is full.

---
 rtl/imem_loader.sv | 128 ++++++++++++
 tb/tb_imem_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction memory loader: packs a big-endian byte stream into 32-bit words and writes them from word 0 until halt or full.
// Optional IMEM_LOADER_PAD_EN: after the halt word, the rest of memory is filled with the halt word.
module imem_loader #(
    parameter int SIZE_IM = 128,
    parameter int CW      = $clog2(SIZE_IM) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          we,
    output logic [31:0]   waddr,
    output logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic [CW-1:0] word_count
);

    localparam int            IW   = $clog2(SIZE_IM);
    localparam logic [31:0]   HALT = 32'hFC00_0000;
    localparam logic [IW-1:0] LAST = IW'(SIZE_IM - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PAD, DONE} state_t;

    state_t        state, state_nxt;
    logic [23:0]   asm_q;
    logic [1:0]    bcnt;
    logic [IW-1:0] idx;
    logic          take;
    logic          word_end;
    logic [31:0]   new_word;

    // A byte arriving together with start is dropped even though byte_ready is high.
    assign take     = (state == LOAD) && byte_valid && !start;
    assign word_end = take && (bcnt == 2'd3);
    assign new_word = {asm_q, byte_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    if (word_end) begin
                        if (new_word == HALT) begin
`ifdef IMEM_LOADER_PAD_EN
                            state_nxt = (idx == LAST) ? DONE : PAD;
`else
                            state_nxt = DONE;
`endif
                        end else if (idx == LAST) begin
                            state_nxt = DONE;
                        end
                    end
                end
`ifdef IMEM_LOADER_PAD_EN
                PAD: begin
                    if (idx == LAST) begin
                        state_nxt = DONE;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        byte_ready = (state == LOAD);
        busy       = (state == LOAD) || (state == PAD);
        done       = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            overflow   <= 1'b0;
            word_count <= '0;
            idx        <= '0;
            bcnt       <= '0;
            asm_q      <= '0;
        end else begin
            we <= 1'b0;
            if (start) begin
                idx        <= '0;
                bcnt       <= '0;
                word_count <= '0;
                overflow   <= 1'b0;
            end else if (take) begin
                asm_q <= new_word[23:0];
                bcnt  <= bcnt + 2'd1;
                if (bcnt == 2'd3) begin
                    we         <= 1'b1;
                    wdata      <= new_word;
                    waddr      <= {{(30-IW){1'b0}}, idx, 2'b00};
                    idx        <= idx + IW'(1);
                    word_count <= word_count + CW'(1);
                    if (new_word != HALT && idx == LAST) begin
                        overflow <= 1'b1;
                    end
                end
            end
`ifdef IMEM_LOADER_PAD_EN
            else if (state == PAD) begin
                we    <= 1'b1;
                wdata <= HALT;
                waddr <= {{(30-IW){1'b0}}, idx, 2'b00};
                idx   <= idx + IW'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a 128-word and a 4-word instance driven side by side against a stream-level model.
module tb_imem_loader;

`ifdef IMEM_LOADER_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    localparam logic [31:0] HALT = 32'hFC00_0000;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        start [2];
    logic        bvalid[2];
    logic [7:0]  bdata [2];
    logic        o_ready[2], o_we[2], o_busy[2], o_done[2], o_ovf[2];
    logic [31:0] o_waddr[2], o_wdata[2];
    logic [7:0]  cnt0;
    logic [2:0]  cnt1;

    imem_loader #(.SIZE_IM(128)) u0 (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .byte_valid(bvalid[0]),
        .byte_data(bdata[0]), .byte_ready(o_ready[0]), .we(o_we[0]), .waddr(o_waddr[0]),
        .wdata(o_wdata[0]), .busy(o_busy[0]), .done(o_done[0]), .overflow(o_ovf[0]),
        .word_count(cnt0)
    );

    imem_loader #(.SIZE_IM(4)) u1 (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .byte_valid(bvalid[1]),
        .byte_data(bdata[1]), .byte_ready(o_ready[1]), .we(o_we[1]), .waddr(o_waddr[1]),
        .wdata(o_wdata[1]), .busy(o_busy[1]), .done(o_done[1]), .overflow(o_ovf[1]),
        .word_count(cnt1)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Stream-level model: bytes collected per word, words counted, memory size limits applied.
    typedef enum {M_IDLE, M_LOAD, M_PAD, M_DONE} mmode_t;
    mmode_t      mm[2];
    logic [7:0]  mbuf[2][4];
    int          nb[2], nw[2], ns[2];
    bit          ov[2];
    bit          e_we[2];
    logic [31:0] e_wa[2], e_wd[2];
    logic [31:0] m_w;

    function automatic int msize(input int k);
        return (k == 0) ? 128 : 4;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            e_we[k] = 1'b0;
            if (!rst_n[k]) begin
                mm[k] = M_IDLE; nb[k] = 0; nw[k] = 0; ns[k] = 0; ov[k] = 1'b0;
                e_wa[k] = 32'h0; e_wd[k] = 32'h0;
            end else if (start[k]) begin
                mm[k] = M_LOAD; nb[k] = 0; nw[k] = 0; ns[k] = 0; ov[k] = 1'b0;
            end else if (mm[k] == M_LOAD && bvalid[k]) begin
                mbuf[k][nb[k]] = bdata[k];
                nb[k]++;
                if (nb[k] == 4) begin
                    nb[k]   = 0;
                    m_w     = {mbuf[k][0], mbuf[k][1], mbuf[k][2], mbuf[k][3]};
                    e_we[k] = 1'b1;
                    e_wa[k] = 32'(nw[k] * 4);
                    e_wd[k] = m_w;
                    nw[k]++;
                    ns[k]++;
                    if (m_w == HALT)
                        mm[k] = (PAD_EN && nw[k] < msize(k)) ? M_PAD : M_DONE;
                    else if (nw[k] == msize(k)) begin
                        mm[k] = M_DONE;
                        ov[k] = 1'b1;
                    end
                end
            end else if (mm[k] == M_PAD) begin
                e_we[k] = 1'b1;
                e_wa[k] = 32'(nw[k] * 4);
                e_wd[k] = HALT;
                nw[k]++;
                if (nw[k] == msize(k)) mm[k] = M_DONE;
            end
        end
    end

    logic [76:0] exp_v, act_v;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                exp_v = {e_we[k], e_wa[k], e_wd[k], mm[k] == M_LOAD,
                         (mm[k] == M_LOAD) || (mm[k] == M_PAD), mm[k] == M_DONE, ov[k], 8'(ns[k])};
                act_v = {o_we[k], o_waddr[k], o_wdata[k], o_ready[k], o_busy[k], o_done[k], o_ovf[k],
                         (k == 0) ? cnt0 : {5'b0, cnt1}};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL cycle dut%0d t=%0t: got %h expected %h", k, $time, act_v, exp_v);
                end
            end
        end
    end

    logic [63:0] wlog0[$], wlog1[$];
    always @(negedge clk) begin
        if (o_we[0]) wlog0.push_back({o_waddr[0], o_wdata[0]});
        if (o_we[1]) wlog1.push_back({o_waddr[1], o_wdata[1]});
    end

    logic [7:0] stim[$];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input int k);
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
    endtask

    task automatic send_stream(input int k, input bit toggle);
        bit acc;
        for (int i = 0; i < stim.size(); i++) begin
            acc       = 1'b0;
            bvalid[k] = 1'b1;
            bdata[k]  = stim[i];
            for (int t = 0; t < 50 && !acc; t++) begin
                acc = o_ready[k];
                tick();
            end
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL send dut%0d byte %0d: byte_ready got 0 expected 1", k, i);
            end
            if (toggle) begin
                bvalid[k] = 1'b0;
                tick();
            end
        end
        bvalid[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (o_done[k]) break;
            tick();
        end
        checks++;
        if (!o_done[k]) begin
            errors++;
            $display("FAIL wait_done dut%0d: done got 0 expected 1", k);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; start[k] = 1'b0; bvalid[k] = 1'b0; bdata[k] = 8'h00;
        end
        tick();
        tick();
        chk_en = 1'b1;
        check("reset_state", {o_ready[0], o_we[0], o_busy[0], o_done[0], o_ovf[0], cnt0,
                              o_waddr[0], o_wdata[0]}, 128'h0);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        tick();

        // Three-word program, byte_valid held high.
        stim = '{8'h00, 8'h00, 8'h00, 8'h20, 8'h8C, 8'h01, 8'h00, 8'h04, 8'hFC, 8'h00, 8'h00, 8'h00};
        wlog0.delete();
        pulse_start(0);
        send_stream(0, 1'b0);
        wait_done(0, 300);
        check("a_nwrites", 128'(wlog0.size()), PAD_EN ? 128'd128 : 128'd3);
        check("a_w0", 128'(wlog0[0]), 128'h0000_0000_0000_0020);
        check("a_w1", 128'(wlog0[1]), 128'h0000_0004_8C01_0004);
        check("a_w2", 128'(wlog0[2]), 128'h0000_0008_FC00_0000);
        check("a_last", 128'(wlog0[wlog0.size()-1]),
              PAD_EN ? 128'h0000_01FC_FC00_0000 : 128'h0000_0008_FC00_0000);
        check("a_count", 128'(cnt0), 128'd3);
        check("a_ovf", 128'(o_ovf[0]), 128'd0);

        // Same program with gaps between bytes.
        wlog0.delete();
        pulse_start(0);
        send_stream(0, 1'b1);
        wait_done(0, 300);
        check("b_w0", 128'(wlog0[0]), 128'h0000_0000_0000_0020);
        check("b_w1", 128'(wlog0[1]), 128'h0000_0004_8C01_0004);
        check("b_w2", 128'(wlog0[2]), 128'h0000_0008_FC00_0000);
        check("b_count", 128'(cnt0), 128'd3);

        // Four-word memory filled without a halt word.
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10};
        wlog1.delete();
        pulse_start(1);
        send_stream(1, 1'b0);
        wait_done(1, 50);
        check("c_nwrites", 128'(wlog1.size()), 128'd4);
        check("c_w0", 128'(wlog1[0]), 128'h0000_0000_0102_0304);
        check("c_w3", 128'(wlog1[3]), 128'h0000_000C_0D0E_0F10);
        check("c_flags", {o_ovf[1], o_done[1], o_ready[1], cnt1}, {3'b110, 3'd4});
        bvalid[1] = 1'b1;
        bdata[1]  = 8'h55;
        for (int i = 0; i < 5; i++) tick();
        bvalid[1] = 1'b0;
        check("c_no_more", {128'(wlog1.size()), 120'(cnt1)}, {128'd4, 120'd4});

        // Restart in the middle of a word, colliding with a third byte.
        stim = '{8'hAA, 8'hBB};
        wlog0.delete();
        pulse_start(0);
        send_stream(0, 1'b0);
        start[0] = 1'b1; bvalid[0] = 1'b1; bdata[0] = 8'hCC;
        tick();
        start[0] = 1'b0; bvalid[0] = 1'b0;
        stim = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_stream(0, 1'b0);
        tick();
        tick();
        check("d_nwrites", 128'(wlog0.size()), 128'd1);
        check("d_w0", 128'(wlog0[0]), 128'h0000_0000_1122_3344);

        // Halt at word 0 then reset a few cycles later (inside the fill when it is built).
        stim = '{8'hFC, 8'h00, 8'h00, 8'h00};
        pulse_start(0);
        send_stream(0, 1'b0);
        tick();
        tick();
        rst_n[0] = 1'b0;
        tick();
        rst_n[0] = 1'b1;
        check("e_reset", {o_ready[0], o_we[0], o_busy[0], o_done[0], o_ovf[0], cnt0,
                          o_waddr[0], o_wdata[0]}, 128'h0);
        wlog0.delete();
        bvalid[0] = 1'b1;
        bdata[0]  = 8'h77;
        for (int i = 0; i < 4; i++) tick();
        bvalid[0] = 1'b0;
        check("e_idle", {128'(wlog0.size()), 127'(o_ready[0])}, 255'h0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
